// File: rtl/uart_row_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_row_packet_parser
//  Purpose  : Parses UART row packets (Y_LO, Y_HI, pixel bytes, stop byte)
//             into frame-buffer writes and queues per-byte answer codes.
//  Revision : 1.0  initial release
// ============================================================================
module uart_row_packet_parser #(
   parameter int         ROW_BYTES      = 240,
   parameter int         ROW_W          = 9,
   parameter logic [7:0] STOP_BYTE      = 8'hDD,
   parameter logic [7:0] ACK_ROW        = 8'hCC,
   parameter logic [7:0] ACK_DATA       = 8'hAA,
   parameter logic [7:0] ACK_OK         = 8'hFF,
   parameter logic [7:0] ACK_SHORT      = 8'h11,
   parameter int         TIMEOUT_CYCLES = 500_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_data,
   input  logic               rx_done,
   input  logic               tx_busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic               wr_en,
   output logic [ROW_W+7:0]   wr_addr,
   output logic [7:0]         wr_data,
   output logic               row_valid,
   output logic [ROW_W-1:0]   row_idx,
   output logic               ans_ovf
);

   localparam int         ADDR_W     = ROW_W + 8;
   localparam int         FIFO_DEPTH = 4;
   localparam int         IDLE_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] LAST_COL   = 8'(ROW_BYTES - 1);
   localparam logic [7:0] ROW_COUNT8 = 8'(ROW_BYTES);

   typedef enum logic [1:0] {S_YLO, S_YHI, S_DATA, S_STOP} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_WBUSY, T_WDONE}     tx_state_t;

   rx_state_t            rx_state_q, rx_state_d;
   logic [7:0]           ylo_q, ylo_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [7:0]           col_q, col_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [7:0]           wr_data_q, wr_data_d;
   logic                 row_valid_q, row_valid_d;
   logic [ROW_W-1:0]     row_idx_q, row_idx_d;
   logic                 ans_ovf_q, ans_ovf_d;

   logic [7:0]           fifo_mem_q [FIFO_DEPTH];
   logic [7:0]           fifo_mem_d [FIFO_DEPTH];
   logic [1:0]           wr_ptr_q, wr_ptr_d;
   logic [1:0]           rd_ptr_q, rd_ptr_d;
   logic [2:0]           fifo_cnt_q, fifo_cnt_d;

   tx_state_t            tx_state_q, tx_state_d;
   logic [1:0]           guard_q, guard_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;

   logic [1:0]           push_n;
   logic [7:0]           push_b0;
   logic [7:0]           push_b1;
   logic                 pop;
   logic [2:0]           free_slots;
   logic                 push_ok;
   logic [ADDR_W-1:0]    pix_addr;

   assign pix_addr = ADDR_W'(row_q) * ADDR_W'(ROW_BYTES) + ADDR_W'(col_q);

   // Receive-side packet FSM; produces at most one answer event per cycle.
   always_comb begin
      rx_state_d  = rx_state_q;
      ylo_d       = ylo_q;
      row_d       = row_q;
      col_d       = col_q;
      idle_d      = idle_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      row_valid_d = 1'b0;
      row_idx_d   = row_idx_q;
      push_n      = 2'd0;
      push_b0     = 8'h00;
      push_b1     = 8'h00;
      if (rx_done) begin
         idle_d = '0;
         unique case (rx_state_q)
            S_YLO: begin
               ylo_d      = rx_data;
               col_d      = 8'h00;
               push_n     = 2'd1;
               push_b0    = ACK_ROW;
               rx_state_d = S_YHI;
            end
            S_YHI: begin
               row_d      = ROW_W'({rx_data, ylo_q});
               col_d      = 8'h00;
               push_n     = 2'd1;
               push_b0    = ACK_ROW;
               rx_state_d = S_DATA;
            end
            S_DATA: begin
               wr_en_d    = 1'b1;
               wr_addr_d  = pix_addr;
               wr_data_d  = rx_data;
               push_n     = 2'd1;
               push_b0    = ACK_DATA;
               col_d      = col_q + 8'd1;
               if (col_q == LAST_COL) begin
                  rx_state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (rx_data == STOP_BYTE) begin
                  push_n      = 2'd1;
                  push_b0     = ACK_OK;
                  row_valid_d = 1'b1;
                  row_idx_d   = row_q;
               end else begin
                  push_n  = 2'd2;
                  push_b0 = ACK_SHORT;
                  push_b1 = ROW_COUNT8;
               end
               rx_state_d = S_YLO;
            end
         endcase
      end else if (rx_state_q != S_YLO) begin
         if (idle_q == IDLE_LAST) begin
            // col_q is still 0 while waiting for Y_HI, so that case reports 0.
            push_n     = 2'd2;
            push_b0    = ACK_SHORT;
            push_b1    = col_q;
            idle_d     = '0;
            rx_state_d = S_YLO;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   // Transmit handshake: one answer in flight, guarded against a silent transmitter.
   always_comb begin
      tx_state_d = tx_state_q;
      guard_d    = guard_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop        = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            if ((fifo_cnt_q != 3'd0) && !tx_busy) begin
               pop        = 1'b1;
               tx_data_d  = fifo_mem_q[rd_ptr_q];
               tx_start_d = 1'b1;
               guard_d    = 2'd0;
               tx_state_d = T_WBUSY;
            end
         end
         T_WBUSY: begin
            if (tx_busy || (guard_q == 2'd3)) begin
               tx_state_d = T_WDONE;
            end else begin
               guard_d = guard_q + 2'd1;
            end
         end
         T_WDONE: begin
            if (!tx_busy) begin
               tx_state_d = T_IDLE;
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // A slot freed by this cycle's pop is usable by this cycle's push.
   always_comb begin
      free_slots = 3'(FIFO_DEPTH) - fifo_cnt_q + {2'b00, pop};
      push_ok    = ({1'b0, push_n} <= free_slots);
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q + {1'b0, pop};
      ans_ovf_d  = ans_ovf_q;
      fifo_cnt_d = fifo_cnt_q - {2'b00, pop};
      if (push_n != 2'd0) begin
         if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = push_b0;
            if (push_n == 2'd2) begin
               fifo_mem_d[wr_ptr_q + 2'd1] = push_b1;
            end
            wr_ptr_d   = wr_ptr_q + push_n;
            fifo_cnt_d = fifo_cnt_q + {1'b0, push_n} - {2'b00, pop};
         end else begin
            ans_ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q  <= S_YLO;
         ylo_q       <= 8'h00;
         row_q       <= '0;
         col_q       <= 8'h00;
         idle_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         row_valid_q <= 1'b0;
         row_idx_q   <= '0;
         ans_ovf_q   <= 1'b0;
         fifo_mem_q  <= '{default: 8'h00};
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         fifo_cnt_q  <= 3'd0;
         tx_state_q  <= T_IDLE;
         guard_q     <= 2'd0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
      end else begin
         rx_state_q  <= rx_state_d;
         ylo_q       <= ylo_d;
         row_q       <= row_d;
         col_q       <= col_d;
         idle_q      <= idle_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         row_valid_q <= row_valid_d;
         row_idx_q   <= row_idx_d;
         ans_ovf_q   <= ans_ovf_d;
         fifo_mem_q  <= fifo_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         tx_state_q  <= tx_state_d;
         guard_q     <= guard_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign row_valid = row_valid_q;
   assign row_idx   = row_idx_q;
   assign ans_ovf   = ans_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_row_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_row_packet_parser
//  Purpose  : Self-checking bench: table-driven packets, random packets and
//             hand-written overflow / reset / pop-collision sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_row_packet_parser;

   localparam int RB       = 240;
   localparam int TO_CYC   = 200;
   localparam int BUSY_LEN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        wr_en;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        row_valid;
   logic [8:0]  row_idx;
   logic        ans_ovf;

   uart_row_packet_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .row_valid(row_valid), .row_idx(row_idx), .ans_ovf(ans_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] y;
      int          n;
      int          kind;   // 0 good stop, 1 bad stop, 2 timeout after n data, 3 timeout after Y_LO
      logic [7:0]  stopb;
      logic [7:0]  tail0;
      logic [7:0]  tail1;
      int          rv;
   } vec_t;

   vec_t       tbl [7];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] got_ans [$];
   logic [7:0] exp_ans [$];
   int         got_wr [$];
   int         exp_wr [$];
   int         got_rv [$];
   int         exp_rv [$];
   logic [7:0] pkt [RB];
   logic       hold_busy = 1'b0;
   logic       no_busy   = 1'b0;
   logic       exp_ovf   = 1'b0;
   int         busy_cnt  = 0;
   logic [7:0] held      = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transmitter model and output monitors, sampled away from the rising edge.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else if (tx_start) begin
         got_ans.push_back(tx_data);
         held     = tx_data;
         busy_cnt = no_busy ? 0 : BUSY_LEN;
      end else if (busy_cnt > 0) begin
         check("tx_data_hold", int'(tx_data), int'(held));
         busy_cnt--;
      end
      tx_busy = hold_busy || (busy_cnt > 0);
      if (wr_en)     got_wr.push_back(int'({wr_addr, wr_data}));
      if (row_valid) got_rv.push_back(int'(row_idx));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   // Reference: what one packet must produce, straight from the packet rules.
   task automatic model(input logic [15:0] y, input int n, input int kind, input logic [7:0] stopb);
      int row;
      row = int'(y) % 512;
      exp_ans.push_back(8'hCC);
      if (kind == 3) begin
         exp_ans.push_back(8'h11);
         exp_ans.push_back(8'h00);
         return;
      end
      exp_ans.push_back(8'hCC);
      for (int i = 0; i < n; i++) begin
         exp_ans.push_back(8'hAA);
         exp_wr.push_back((row * RB + i) * 256 + int'(pkt[i]));
      end
      if (kind == 0 && stopb == 8'hDD) begin
         exp_ans.push_back(8'hFF);
         exp_rv.push_back(row);
      end else begin
         exp_ans.push_back(8'h11);
         exp_ans.push_back(8'(n));
      end
   endtask

   task automatic run_pkt(input logic [15:0] y, input int n, input int kind, input logic [7:0] stopb);
      logic [7:0] lo, hi;
      lo = y[7:0];
      hi = y[15:8];
      for (int i = 0; i < RB; i++) pkt[i] = 8'($urandom);
      model(y, n, kind, (kind == 0) ? 8'hDD : stopb);
      send(lo, $urandom_range(12, 8));
      if (kind != 3) send(hi, $urandom_range(12, 8));
      for (int i = 0; i < n; i++) send(pkt[i], $urandom_range(12, 8));
      if (kind <= 1) send((kind == 0) ? 8'hDD : stopb, 4);
      else repeat (TO_CYC + 20) @(posedge clk);
   endtask

   task automatic compare_all(input string tag);
      int waited;
      waited = 0;
      while (got_ans.size() < exp_ans.size() && waited < 3000) begin
         @(posedge clk);
         waited++;
      end
      repeat (20) @(posedge clk);
      check($sformatf("%s ans_count", tag), got_ans.size(), exp_ans.size());
      for (int i = 0; i < exp_ans.size() && i < got_ans.size(); i++)
         check($sformatf("%s ans[%0d]", tag, i), int'(got_ans[i]), int'(exp_ans[i]));
      check($sformatf("%s wr_count", tag), got_wr.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
         check($sformatf("%s wr[%0d]", tag, i), got_wr[i], exp_wr[i]);
      check($sformatf("%s row_valid_count", tag), got_rv.size(), exp_rv.size());
      for (int i = 0; i < exp_rv.size() && i < got_rv.size(); i++)
         check($sformatf("%s row_idx", tag), got_rv[i], exp_rv[i]);
      check($sformatf("%s ans_ovf", tag), int'(ans_ovf), int'(exp_ovf));
   endtask

   task automatic clear_q();
      got_ans.delete(); exp_ans.delete();
      got_wr.delete();  exp_wr.delete();
      got_rv.delete();  exp_rv.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, " tx_start"},  int'(tx_start),  0);
      check({tag, " tx_data"},   int'(tx_data),   0);
      check({tag, " wr_en"},     int'(wr_en),     0);
      check({tag, " wr_addr"},   int'(wr_addr),   0);
      check({tag, " wr_data"},   int'(wr_data),   0);
      check({tag, " row_valid"}, int'(row_valid), 0);
      check({tag, " row_idx"},   int'(row_idx),   0);
      check({tag, " ans_ovf"},   int'(ans_ovf),   0);
   endtask

   initial begin
      int s, kind, n;
      logic [7:0] sb;
      tbl[0] = '{16'h2201, 240, 0, 8'hDD, 8'hFF, 8'h00, 1};
      tbl[1] = '{16'h0001,  10, 2, 8'h00, 8'h11, 8'h0A, 0};
      tbl[2] = '{16'h0001, 240, 1, 8'h55, 8'h11, 8'hF0, 0};
      tbl[3] = '{16'h01FF, 240, 0, 8'hDD, 8'hFF, 8'h00, 1};
      tbl[4] = '{16'h0005,   0, 2, 8'h00, 8'h11, 8'h00, 0};
      tbl[5] = '{16'h7777,   0, 3, 8'h00, 8'h11, 8'h00, 0};
      tbl[6] = '{16'h0100, 240, 2, 8'h00, 8'h11, 8'hF0, 0};

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int t = 0; t < 7; t++) begin
         run_pkt(tbl[t].y, tbl[t].n, tbl[t].kind, tbl[t].stopb);
         compare_all($sformatf("tbl%0d", t));
         s = got_ans.size();
         if (tbl[t].kind == 0) begin
            check($sformatf("tbl%0d tail", t), (s > 0) ? int'(got_ans[s-1]) : -1, int'(tbl[t].tail0));
         end else begin
            check($sformatf("tbl%0d tail0", t), (s > 1) ? int'(got_ans[s-2]) : -1, int'(tbl[t].tail0));
            check($sformatf("tbl%0d tail1", t), (s > 0) ? int'(got_ans[s-1]) : -1, int'(tbl[t].tail1));
         end
         check($sformatf("tbl%0d rv", t), got_rv.size(), tbl[t].rv);
         clear_q();
      end

      for (int r = 0; r < 5; r++) begin
         kind = $urandom_range(3, 0);
         n    = (kind == 2) ? $urandom_range(239, 0) : ((kind == 3) ? 0 : RB);
         sb   = 8'($urandom);
         if (sb == 8'hDD) sb = 8'h00;
         run_pkt(16'($urandom), n, kind, sb);
         compare_all($sformatf("rand%0d", r));
         clear_q();
      end

      // Silent transmitter: the busy guard must still let every answer out.
      no_busy = 1'b1;
      run_pkt(16'h0003, 0, 3, 8'h00);
      compare_all("guard");
      clear_q();
      no_busy = 1'b0;

      // Queue overflow while the transmitter is held busy.
      hold_busy = 1'b1;
      @(posedge clk);
      for (int i = 0; i < RB; i++) pkt[i] = 8'($urandom);
      send(8'h01, 2);
      send(8'h00, 2);
      for (int i = 0; i < 4; i++) send(pkt[i], 2);
      check("ovf set", int'(ans_ovf), 1);
      exp_ans = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'h11, 8'h04};
      for (int i = 0; i < 4; i++) exp_wr.push_back((RB + i) * 256 + int'(pkt[i]));
      exp_ovf   = 1'b1;
      hold_busy = 1'b0;
      repeat (TO_CYC + 20) @(posedge clk);
      compare_all("ovf");
      clear_q();

      // Reset in the middle of a packet with answers still queued.
      for (int i = 0; i < RB; i++) pkt[i] = 8'($urandom);
      model(16'h0001, 100, 2, 8'h00);
      void'(exp_ans.pop_back());
      void'(exp_ans.pop_back());
      send(8'h01, 10);
      send(8'h00, 10);
      for (int i = 0; i < 100; i++) send(pkt[i], $urandom_range(12, 8));
      compare_all("pre_rst");
      clear_q();
      hold_busy = 1'b1;
      send(pkt[100], 2);
      send(pkt[101], 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check_zero("mid_rst");
      rst = 1'b0;
      hold_busy = 1'b0;
      exp_ovf = 1'b0;
      clear_q();
      repeat (30) @(posedge clk);
      check("fifo flushed", got_ans.size(), 0);
      run_pkt(16'h0000, 3, 2, 8'h00);
      compare_all("post_rst");
      clear_q();

      // Y_HI arrives on the very edge the queued Y_LO answer is popped.
      for (int i = 0; i < RB; i++) pkt[i] = 8'($urandom);
      model(16'hE001, 5, 2, 8'h00);
      hold_busy = 1'b1;
      send(8'h01, 3);
      @(posedge clk); #1;
      hold_busy = 1'b0;
      rx_data   = 8'hE0;
      rx_done   = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      repeat (10) @(posedge clk);
      for (int i = 0; i < 5; i++) send(pkt[i], $urandom_range(12, 8));
      repeat (TO_CYC + 20) @(posedge clk);
      compare_all("pop_push");
      clear_q();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
